// File: rtl/or1k_noc_vchannel_mux.sv
// Virtual-channel link mux: per-channel flit FIFOs merged onto one NoC link
// by a round-robin arbiter that can either hold a channel for a whole packet or interleave per flit.
module or1k_noc_vchannel_mux #(
  parameter int FLIT_WIDTH   = 32,
  parameter int CHANNELS     = 2,
  parameter int BUFFER_DEPTH = 4,
  parameter int PACKET_LOCK  = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [CHANNELS*FLIT_WIDTH-1:0]                in_flit,
  input  logic [CHANNELS-1:0]                           in_last,
  input  logic [CHANNELS-1:0]                           in_valid,
  output logic [CHANNELS-1:0]                           in_ready,
  output logic [FLIT_WIDTH-1:0]                         out_flit,
  output logic                                          out_last,
  output logic                                          out_valid,
  output logic [CHANNELS-1:0]                           out_channel,
  input  logic                                          out_ready,
  output logic [CHANNELS*($clog2(BUFFER_DEPTH)+1)-1:0]  in_count
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, OFFER, LOCKED} state_t;

  state_t               state_reg, state_next;
  logic [GW-1:0]        grant_reg, grant_next;
  logic [GW-1:0]        ptr_reg, ptr_next;
  logic [GW-1:0]        cand;
  logic [GW-1:0]        active;
  logic                 cand_found;
  logic                 have_grant;
  logic                 xfer;
  logic [CHANNELS-1:0]  nonempty;
  logic [CHANNELS-1:0]  push;
  logic [CHANNELS-1:0]  pop;
  logic [CHANNELS-1:0]  head_last;
  logic [FLIT_WIDTH-1:0] head_flit [CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_fifo
      logic [FLIT_WIDTH:0] mem [BUFFER_DEPTH];
      logic [AW-1:0]       wr_ptr_reg;
      logic [AW-1:0]       rd_ptr_reg;
      logic [CW-1:0]       count_reg;

      // Ready depends on registered occupancy only; a pop never frees space in the same cycle.
      assign in_ready[gi]           = ~rst & (count_reg < CW'(BUFFER_DEPTH));
      assign push[gi]               = in_valid[gi] & in_ready[gi];
      assign pop[gi]                = xfer & (active == GW'(gi));
      assign nonempty[gi]           = (count_reg != '0);
      assign head_flit[gi]          = mem[rd_ptr_reg][FLIT_WIDTH-1:0];
      assign head_last[gi]          = mem[rd_ptr_reg][FLIT_WIDTH];
      assign in_count[gi*CW +: CW]  = rst ? '0 : count_reg;

      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem[wr_ptr_reg] <= {in_last[gi], in_flit[gi*FLIT_WIDTH +: FLIT_WIDTH]};
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  // Round-robin scan starting just after the last granted channel.
  always_comb begin
    int idx;
    idx        = 0;
    cand       = ptr_reg;
    cand_found = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(ptr_reg) + i) % CHANNELS;
      if (!cand_found && nonempty[idx]) begin
        cand       = GW'(idx);
        cand_found = 1'b1;
      end
    end
  end

  // In IDLE the grant is taken straight from the scan so an offer costs no extra cycle.
  assign active      = (state_reg == IDLE) ? cand : grant_reg;
  assign have_grant  = (state_reg != IDLE) | cand_found;
  assign out_valid   = ~rst & have_grant & nonempty[active];
  assign xfer        = out_valid & out_ready;
  assign out_flit    = out_valid ? head_flit[active] : '0;
  assign out_last    = out_valid & head_last[active];
  assign out_channel = out_valid ? (CHANNELS'(1) << active) : '0;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (cand_found) begin
          grant_next = cand;
          state_next = OFFER;
        end
      end
      default: ;
    endcase
    if (xfer) begin
      if ((PACKET_LOCK != 0) && !head_last[active]) begin
        grant_next = active;
        state_next = LOCKED;
      end else begin
        ptr_next   = active;
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      ptr_reg   <= GW'(CHANNELS - 1);
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
    end
  end

endmodule

// File: tb/tb_or1k_noc_vchannel_mux.sv
// Scoreboard bench: one packet-lock and one interleaving instance share stimulus;
// expected link traffic is queued per instance and checked by a negedge monitor.
module tb_or1k_noc_vchannel_mux;

  localparam int W  = 32;
  localparam int CH = 2;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*W-1:0] in_flit;
  logic [CH-1:0]   in_last;
  logic [CH-1:0]   in_valid;
  logic            out_ready;

  logic [CH-1:0]    in_ready_l, in_ready_i;
  logic [W-1:0]     out_flit_l, out_flit_i;
  logic             out_last_l, out_last_i;
  logic             out_valid_l, out_valid_i;
  logic [CH-1:0]    out_channel_l, out_channel_i;
  logic [CH*CW-1:0] in_count_l, in_count_i;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [CH+W:0] exp_l[$];
  logic [CH+W:0] exp_i[$];

  always #5 clk = ~clk;

  or1k_noc_vchannel_mux #(.FLIT_WIDTH(W), .CHANNELS(CH), .BUFFER_DEPTH(D), .PACKET_LOCK(1)) dut_l (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready_l), .out_flit(out_flit_l), .out_last(out_last_l), .out_valid(out_valid_l),
    .out_channel(out_channel_l), .out_ready(out_ready), .in_count(in_count_l)
  );

  or1k_noc_vchannel_mux #(.FLIT_WIDTH(W), .CHANNELS(CH), .BUFFER_DEPTH(D), .PACKET_LOCK(0)) dut_i (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready_i), .out_flit(out_flit_i), .out_last(out_last_i), .out_valid(out_valid_i),
    .out_channel(out_channel_i), .out_ready(out_ready), .in_count(in_count_i)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      passes++;
      $display("ok   %s value=%h", name, act);
    end
  endtask

  function automatic logic [CH+W:0] ex(input logic [CH-1:0] ch, input logic l, input logic [W-1:0] f);
    return {ch, l, f};
  endfunction

  task automatic exp_both(input logic [CH-1:0] ch, input logic l, input logic [W-1:0] f);
    exp_l.push_back(ex(ch, l, f));
    exp_i.push_back(ex(ch, l, f));
  endtask

  // Monitor: every accepted link flit is compared against the head of its instance queue.
  always @(negedge clk) begin
    if (out_valid_l && out_ready) begin
      if (exp_l.size() == 0) begin
        checks++; fails++;
        $display("FAIL lock_unexpected actual=%h required=none", {out_channel_l, out_last_l, out_flit_l});
      end else begin
        check("lock_xfer", {out_channel_l, out_last_l, out_flit_l}, exp_l.pop_front());
      end
    end
    if (out_valid_i && out_ready) begin
      if (exp_i.size() == 0) begin
        checks++; fails++;
        $display("FAIL ilv_unexpected actual=%h required=none", {out_channel_i, out_last_i, out_flit_i});
      end else begin
        check("ilv_xfer", {out_channel_i, out_last_i, out_flit_i}, exp_i.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int c, input logic v, input logic l, input logic [W-1:0] f);
    in_valid[c]      = v;
    in_last[c]       = l;
    in_flit[c*W +: W] = f;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    in_valid = '0;
    @(negedge clk);
    check("rst_in_ready", {in_ready_l, in_ready_i}, '0);
    check("rst_out_valid", {out_valid_l, out_valid_i}, '0);
    check("rst_in_count", {in_count_l, in_count_i}, '0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {in_ready_l, in_ready_i}, {2*CH{1'b1}});
    tick();
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while ((exp_l.size() != 0 || exp_i.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    tick();
    check({name, "_lock_left"}, exp_l.size(), 0);
    check({name, "_ilv_left"}, exp_i.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    logic rdy;
    rst = 1'b1; in_flit = '0; in_last = '0; in_valid = '0; out_ready = 1'b0;

    // T1: single 3-flit packet on ch0, 1-cycle latency, last only on tail
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) exp_both(2'b01, i == 2, 32'hA0 + i);
    set_in(0, 1'b1, 1'b0, 32'hA0);
    @(negedge clk);
    check("t1_no_same_cycle_valid", out_valid_l, 1'b0);
    tick();
    @(negedge clk);
    check("t1_valid_after_1", {out_valid_l, out_valid_i}, 2'b11);
    #4;
    set_in(0, 1'b1, 1'b0, 32'hA1);
    tick();
    set_in(0, 1'b1, 1'b1, 32'hA2);
    tick();
    in_valid = '0;
    drain("t1", 10);

    // T2: simultaneous 4-flit packets on both channels
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_l.push_back(ex(2'b01, i == 3, 32'h100 + i));
    for (int i = 0; i < 4; i++) exp_l.push_back(ex(2'b10, i == 3, 32'h200 + i));
    for (int i = 0; i < 4; i++) begin
      exp_i.push_back(ex(2'b01, i == 3, 32'h100 + i));
      exp_i.push_back(ex(2'b10, i == 3, 32'h200 + i));
    end
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1'b1, i == 3, 32'h100 + i);
      set_in(1, 1'b1, i == 3, 32'h200 + i);
      tick();
    end
    in_valid = '0;
    drain("t2a", 20);
    // lone ch0 packet leaves the pointer on ch0, so the next contested pair starts on ch1
    exp_both(2'b01, 1'b1, 32'h300);
    set_in(0, 1'b1, 1'b1, 32'h300);
    tick();
    in_valid = '0;
    drain("t2b", 6);
    exp_l.push_back(ex(2'b10, 1'b0, 32'h500));
    exp_l.push_back(ex(2'b10, 1'b1, 32'h501));
    exp_l.push_back(ex(2'b01, 1'b0, 32'h400));
    exp_l.push_back(ex(2'b01, 1'b1, 32'h401));
    exp_i.push_back(ex(2'b10, 1'b0, 32'h500));
    exp_i.push_back(ex(2'b01, 1'b0, 32'h400));
    exp_i.push_back(ex(2'b10, 1'b1, 32'h501));
    exp_i.push_back(ex(2'b01, 1'b1, 32'h401));
    for (int i = 0; i < 2; i++) begin
      set_in(0, 1'b1, i == 1, 32'h400 + i);
      set_in(1, 1'b1, i == 1, 32'h500 + i);
      tick();
    end
    in_valid = '0;
    drain("t2c", 12);

    // T4: backpressure fills ch0 FIFO, head flit held, then drains in order
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) exp_both(2'b01, i == 5, 32'h600 + i);
    acc = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (acc < 6) set_in(0, 1'b1, acc == 5, 32'h600 + acc);
      else in_valid[0] = 1'b0;
      @(negedge clk);
      rdy = in_ready_l[0];
      if (cyc >= 1) check("t4_hold_head", {out_valid_l, out_flit_l, out_valid_i, out_flit_i},
                          {1'b1, 32'h600, 1'b1, 32'h600});
      tick();
      if (rdy && acc < 6) acc++;
    end
    @(negedge clk);
    check("t4_accepted", acc, 4);
    check("t4_in_count", {in_count_l[CW-1:0], in_count_i[CW-1:0]}, {3'd4, 3'd4});
    check("t4_in_ready_low", {in_ready_l[0], in_ready_i[0]}, 2'b00);
    tick();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && acc < 6; cyc++) begin
      set_in(0, 1'b1, acc == 5, 32'h600 + acc);
      @(negedge clk);
      rdy = in_ready_l[0];
      tick();
      if (rdy) acc++;
    end
    in_valid = '0;
    check("t4_all_accepted", acc, 6);
    drain("t4", 12);

    // T5: offered grant is not stolen by a newly non-empty channel
    do_reset();
    out_ready = 1'b0;
    exp_both(2'b10, 1'b1, 32'h700);
    exp_both(2'b01, 1'b1, 32'h800);
    set_in(1, 1'b1, 1'b1, 32'h700);
    tick();
    in_valid = '0;
    set_in(0, 1'b1, 1'b1, 32'h800);
    tick();
    in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_grant_held", {out_channel_l, out_flit_l, out_channel_i, out_flit_i},
            {2'b10, 32'h700, 2'b10, 32'h700});
      tick();
    end
    out_ready = 1'b1;
    drain("t5", 8);

    // T6: reset mid-packet discards partial ch0 data
    do_reset();
    out_ready = 1'b0;
    set_in(0, 1'b1, 1'b0, 32'h900);
    tick();
    set_in(0, 1'b1, 1'b0, 32'h901);
    tick();
    in_valid = '0;
    @(negedge clk);
    check("t6_pre_rst_count", in_count_l[CW-1:0], 3'd2);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_out_valid", {out_valid_l, out_valid_i}, 2'b00);
    check("t6_rst_in_ready", {in_ready_l, in_ready_i}, 4'b0000);
    check("t6_rst_in_count", {in_count_l, in_count_i}, '0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_empty", {out_valid_l, out_valid_i, in_count_l, in_count_i}, '0);
    tick();
    out_ready = 1'b1;
    exp_both(2'b10, 1'b0, 32'hA00);
    exp_both(2'b10, 1'b1, 32'hA01);
    set_in(1, 1'b1, 1'b0, 32'hA00);
    tick();
    set_in(1, 1'b1, 1'b1, 32'hA01);
    tick();
    in_valid = '0;
    drain("t6", 8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
